// File: rtl/btb_update_pkg.sv
// Shared constants for the 2-way, 8-set branch target buffer: set/way field
// layout, 2-bit counter encodings and a helper that packs a valid way.
package btb_update_pkg;

  localparam int SETS    = 8;
  localparam int INDEX_W = 3;
  localparam int TAG_W   = 27;
  localparam int WAY_W   = 64;
  localparam int SET_W   = 2 * WAY_W;

  localparam int VALID_BIT = 63;
  localparam int TAG_HI    = 62;
  localparam int TAG_LO    = 36;
  localparam int TGT_HI    = 35;
  localparam int TGT_LO    = 4;
  localparam int ST_HI     = 3;
  localparam int ST_LO     = 2;

  localparam logic [1:0] STRONG_NOT_TAKEN = 2'b00;
  localparam logic [1:0] WEAK_NOT_TAKEN   = 2'b01;
  localparam logic [1:0] STRONG_TAKEN     = 2'b10;
  localparam logic [1:0] WEAK_TAKEN       = 2'b11;

  // Low two bits of a way are reserved and always written as zero.
  function automatic logic [WAY_W-1:0] make_way(input logic [TAG_W-1:0] tag,
                                                input logic [31:0]      target,
                                                input logic [1:0]       state);
    make_way = {1'b1, tag, target, state, 2'b00};
  endfunction

endpackage

// File: rtl/btb_state_next.sv
// Pure 2-bit branch counter transition; the MSB of the state is the
// predict-taken bit.
module btb_state_next
  import btb_update_pkg::*;
(
  input  logic [1:0] state,
  input  logic       taken,
  output logic [1:0] next_state
);

  always_comb begin
    next_state = state;
    if (taken) begin
      case (state)
        STRONG_NOT_TAKEN: next_state = WEAK_NOT_TAKEN;
        WEAK_NOT_TAKEN:   next_state = STRONG_TAKEN;
        STRONG_TAKEN:     next_state = STRONG_TAKEN;
        default:          next_state = STRONG_TAKEN;
      endcase
    end else begin
      case (state)
        STRONG_NOT_TAKEN: next_state = STRONG_NOT_TAKEN;
        WEAK_NOT_TAKEN:   next_state = STRONG_NOT_TAKEN;
        STRONG_TAKEN:     next_state = WEAK_TAKEN;
        default:          next_state = WEAK_NOT_TAKEN;
      endcase
    end
  end

endmodule

// File: rtl/btb_update.sv
// BTB write side: owns the set array and LRU bits, serves the IF read port,
// and retires EX branch updates through a 2-stage read-modify-write.
module btb_update
  import btb_update_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_index,
  output logic [SET_W-1:0]   read_set,
  output logic [SETS-1:0]    lru,
  input  logic               if_lru_we,
  input  logic [INDEX_W-1:0] if_lru_index,
  input  logic               if_next_lru,
  input  logic               upd_valid,
  input  logic [31:0]        upd_pc,
  input  logic [31:0]        upd_target,
  input  logic               upd_taken,
  output logic               upd_done
);

  logic [SET_W-1:0] array [SETS];

  logic               s1_valid;
  logic [INDEX_W-1:0] s1_idx;
  logic [TAG_W-1:0]   s1_tag;
  logic [31:0]        s1_target;
  logic               s1_taken;
  logic [SET_W-1:0]   s1_snap;

  logic               s2_valid;
  logic [INDEX_W-1:0] s2_idx;
  logic [TAG_W-1:0]   s2_tag;
  logic [31:0]        s2_target;
  logic               s2_taken;
  logic [SET_W-1:0]   s2_set;

  logic [WAY_W-1:0] way0;
  logic [WAY_W-1:0] way1;
  logic             hit0;
  logic             hit1;
  logic [1:0]       hit_state;
  logic [1:0]       trained;
  logic             alloc_way;
  logic             new_way;
  logic             s2_we;
  logic [WAY_W-1:0] new_entry;
  logic [SET_W-1:0] new_set;

  assign read_set = array[rd_index];
  assign upd_done = s2_valid;

  // S1 takes the set that S2 is about to write so back-to-back updates chain.
  assign s1_snap = (s2_we && (s2_idx == s1_idx)) ? new_set : array[s1_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_idx    <= '0;
      s1_tag    <= '0;
      s1_target <= '0;
      s1_taken  <= 1'b0;
      s2_valid  <= 1'b0;
      s2_idx    <= '0;
      s2_tag    <= '0;
      s2_target <= '0;
      s2_taken  <= 1'b0;
      s2_set    <= '0;
    end else begin
      s1_valid  <= upd_valid;
      s1_idx    <= upd_pc[4:2];
      s1_tag    <= upd_pc[31:5];
      s1_target <= upd_target;
      s1_taken  <= upd_taken;
      s2_valid  <= s1_valid;
      s2_idx    <= s1_idx;
      s2_tag    <= s1_tag;
      s2_target <= s1_target;
      s2_taken  <= s1_taken;
      s2_set    <= s1_snap;
    end
  end

  assign way0 = s2_set[SET_W-1:WAY_W];
  assign way1 = s2_set[WAY_W-1:0];
  assign hit0 = way0[VALID_BIT] && (way0[TAG_HI:TAG_LO] == s2_tag);
  assign hit1 = way1[VALID_BIT] && (way1[TAG_HI:TAG_LO] == s2_tag);
  assign hit_state = hit0 ? way0[ST_HI:ST_LO] : way1[ST_HI:ST_LO];
  assign alloc_way = !way0[VALID_BIT] ? 1'b0 :
                     !way1[VALID_BIT] ? 1'b1 : ~lru[s2_idx];

  btb_state_next u_state_next (
    .state      (hit_state),
    .taken      (s2_taken),
    .next_state (trained)
  );

  // A hit in both ways can only come from corruption; way0 is preferred.
  always_comb begin
    s2_we     = 1'b0;
    new_way   = 1'b0;
    new_entry = '0;
    new_set   = s2_set;
    if (s2_valid && (hit0 || hit1)) begin
      s2_we     = 1'b1;
      new_way   = !hit0;
      new_entry = make_way(s2_tag, s2_target, trained);
    end else if (s2_valid && s2_taken) begin
      s2_we     = 1'b1;
      new_way   = alloc_way;
      new_entry = make_way(s2_tag, s2_target, WEAK_TAKEN);
    end
    if (s2_we) begin
      if (new_way) new_set[WAY_W-1:0] = new_entry;
      else         new_set[SET_W-1:WAY_W] = new_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SETS; i++) array[i] <= '0;
    end else if (s2_we) begin
      array[s2_idx] <= new_set;
    end
  end

  // The S2 write is issued last so it overrides an IF touch of the same set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lru <= '0;
    end else begin
      if (if_lru_we) lru[if_lru_index] <= if_next_lru;
      if (s2_we)     lru[s2_idx] <= new_way;
    end
  end

endmodule

// File: tb/tb_btb_update.sv
// Directed bench for btb_update: a table of single updates with hand-computed
// set/LRU results, plus sequences for back-to-back, LRU collision and reset.
module tb_btb_update;

  logic         clk;
  logic         rst;
  logic [2:0]   rd_index;
  logic [127:0] read_set;
  logic [7:0]   lru;
  logic         if_lru_we;
  logic [2:0]   if_lru_index;
  logic         if_next_lru;
  logic         upd_valid;
  logic [31:0]  upd_pc;
  logic [31:0]  upd_target;
  logic         upd_taken;
  logic         upd_done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0]  pc;
    logic [31:0]  tgt;
    logic         taken;
    logic [2:0]   idx;
    logic [127:0] exp_set;
    logic [7:0]   exp_lru;
  } vec_t;

  vec_t vecs [9];

  btb_update dut (
    .clk          (clk),
    .rst          (rst),
    .rd_index     (rd_index),
    .read_set     (read_set),
    .lru          (lru),
    .if_lru_we    (if_lru_we),
    .if_lru_index (if_lru_index),
    .if_next_lru  (if_next_lru),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_target   (upd_target),
    .upd_taken    (upd_taken),
    .upd_done     (upd_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected way image: valid, tag, target, state, two zero bits.
  function automatic logic [63:0] w(input logic [26:0] tag, input logic [31:0] tgt,
                                    input logic [1:0] st);
    return {1'b1, tag, tgt, st, 2'b00};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Presents one update for a single clock; returns at the negedge after E0.
  task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] tgt,
                               input logic taken);
    @(negedge clk);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_target = tgt;
    upd_taken  = taken;
    @(negedge clk);
    upd_valid  = 1'b0;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_target = tgt;
    upd_taken  = taken;
  endtask

  initial begin
    rst = 1'b1;
    rd_index = '0;
    if_lru_we = 1'b0;
    if_lru_index = '0;
    if_next_lru = 1'b0;
    upd_valid = 1'b0;
    upd_pc = '0;
    upd_target = '0;
    upd_taken = 1'b0;

    vecs[0] = '{32'h104, 32'h200, 1'b1, 3'd1, {w(27'h8, 32'h200, 2'b11), 64'h0}, 8'h00};
    vecs[1] = '{32'h104, 32'h200, 1'b1, 3'd1, {w(27'h8, 32'h200, 2'b10), 64'h0}, 8'h00};
    vecs[2] = '{32'h104, 32'h300, 1'b0, 3'd1, {w(27'h8, 32'h300, 2'b11), 64'h0}, 8'h00};
    vecs[3] = '{32'h104, 32'h300, 1'b0, 3'd1, {w(27'h8, 32'h300, 2'b01), 64'h0}, 8'h00};
    vecs[4] = '{32'h124, 32'h400, 1'b1, 3'd1,
                {w(27'h8, 32'h300, 2'b01), w(27'h9, 32'h400, 2'b11)}, 8'h02};
    vecs[5] = '{32'h144, 32'h500, 1'b1, 3'd1,
                {w(27'hA, 32'h500, 2'b11), w(27'h9, 32'h400, 2'b11)}, 8'h00};
    vecs[6] = '{32'h308, 32'h600, 1'b0, 3'd2, 128'h0, 8'h00};
    vecs[7] = '{32'h124, 32'h400, 1'b0, 3'd1,
                {w(27'hA, 32'h500, 2'b11), w(27'h9, 32'h400, 2'b01)}, 8'h02};
    vecs[8] = '{32'h308, 32'h600, 1'b1, 3'd2, {w(27'h18, 32'h600, 2'b11), 64'h0}, 8'h02};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int s = 0; s < 8; s++) begin
      rd_index = 3'(s);
      #1;
      checkOutput($sformatf("reset set%0d", s), read_set, 128'h0);
    end
    checkOutput("reset lru", {120'h0, lru}, 128'h0);
    checkOutput("reset done", {127'h0, upd_done}, 128'h0);

    for (int i = 0; i < 9; i++) begin
      rd_index = vecs[i].idx;
      applyStimulus(vecs[i].pc, vecs[i].tgt, vecs[i].taken);
      @(negedge clk);
      checkOutput($sformatf("vec%0d done", i), {127'h0, upd_done}, 128'h1);
      @(negedge clk);
      checkOutput($sformatf("vec%0d set", i), read_set, vecs[i].exp_set);
      checkOutput($sformatf("vec%0d lru", i), {120'h0, lru}, {120'h0, vecs[i].exp_lru});
      checkOutput($sformatf("vec%0d done low", i), {127'h0, upd_done}, 128'h0);
    end

    // Back-to-back not-taken on way0 (state 11): 11 -> 01 -> 00.
    rd_index = 3'd1;
    @(negedge clk); drive(32'h144, 32'h700, 1'b0);
    @(negedge clk); drive(32'h144, 32'h800, 1'b0);
    @(negedge clk); upd_valid = 1'b0;
    checkOutput("b2b nt done1", {127'h0, upd_done}, 128'h1);
    @(negedge clk);
    checkOutput("b2b nt done2", {127'h0, upd_done}, 128'h1);
    @(negedge clk);
    checkOutput("b2b nt set", read_set,
                {w(27'hA, 32'h800, 2'b00), w(27'h9, 32'h400, 2'b01)});
    checkOutput("b2b nt lru", {120'h0, lru}, 128'h0);

    // Back-to-back taken: 00 -> 01 -> 10.
    @(negedge clk); drive(32'h144, 32'h900, 1'b1);
    @(negedge clk); drive(32'h144, 32'h900, 1'b1);
    @(negedge clk); upd_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("b2b t set", read_set,
                {w(27'hA, 32'h900, 2'b10), w(27'h9, 32'h400, 2'b01)});

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst2 lru", {120'h0, lru}, 128'h0);

    // Back-to-back misses into one set: second must see the first allocation.
    rd_index = 3'd1;
    @(negedge clk); drive(32'h104, 32'h200, 1'b1);
    @(negedge clk); drive(32'h124, 32'h400, 1'b1);
    @(negedge clk); upd_valid = 1'b0;
    checkOutput("no bypass", read_set, 128'h0);
    repeat (2) @(negedge clk);
    checkOutput("b2b alloc set", read_set,
                {w(27'h8, 32'h200, 2'b11), w(27'h9, 32'h400, 2'b11)});
    checkOutput("b2b alloc lru", {120'h0, lru}, 128'h2);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // IF touch and S2 write to the same set in one cycle: S2 wins.
    rd_index = 3'd2;
    applyStimulus(32'h308, 32'h600, 1'b1);
    @(negedge clk);
    if_lru_we = 1'b1; if_lru_index = 3'd2; if_next_lru = 1'b1;
    @(negedge clk);
    if_lru_we = 1'b0;
    checkOutput("collide lru", {120'h0, lru}, 128'h0);
    checkOutput("collide set", read_set, {w(27'h18, 32'h600, 2'b11), 64'h0});

    // Touch and S2 write to different sets: both land.
    rd_index = 3'd1;
    applyStimulus(32'h104, 32'h200, 1'b1);
    @(negedge clk);
    if_lru_we = 1'b1; if_lru_index = 3'd2; if_next_lru = 1'b1;
    @(negedge clk);
    if_lru_we = 1'b0;
    checkOutput("split lru", {120'h0, lru}, 128'h04);
    checkOutput("split set", read_set, {w(27'h8, 32'h200, 2'b11), 64'h0});

    @(negedge clk);
    if_lru_we = 1'b1; if_lru_index = 3'd5; if_next_lru = 1'b1;
    @(negedge clk);
    if_lru_we = 1'b0;
    checkOutput("touch lru", {120'h0, lru}, 128'h24);

    // Reset with both stages occupied drops the requests.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rd_index = 3'd1;
    @(negedge clk); drive(32'h124, 32'h400, 1'b1);
    @(negedge clk); drive(32'h104, 32'h200, 1'b1);
    @(negedge clk); upd_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("midrst done", {127'h0, upd_done}, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midrst set1", read_set, 128'h0);
    checkOutput("midrst lru", {120'h0, lru}, 128'h0);
    checkOutput("midrst done after", {127'h0, upd_done}, 128'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
